uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler.sv | 124 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Four-requester round-robin scheduler in front of a UART transmitter FSM.
// Define TX_TIMEOUT_EN to abort a frame that stalls in a wait state for TIMEOUT_CYCLES.
module uart_tx_scheduler #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  Baud_Clk,
  input  logic                  Reset,
  input  logic [3:0]            Req,
  input  logic [4*DATA_W-1:0]   Data,
  output logic [3:0]            Grant,
  output logic [3:0]            Done,
  output logic                  Tx_start,
  output logic [DATA_W-1:0]     Tx_data,
  input  logic                  Tx_busy,
  output logic                  Err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RELEASE   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_owner;
  logic [3:0]        r_grant;
  logic [DATA_W-1:0] r_tx_data;
  logic [1:0]        w_win;
  logic              w_found;
  logic              w_timeout;
  logic              w_in_wait;
  logic              w_start_frame;

  assign w_in_wait     = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_start_frame = (r_state == S_IDLE) && (w_state_next == S_GRANT);

  // Scan downward so the requester closest above the pointer is written last and wins.
  always_comb begin
    logic [1:0] idx;
    w_win   = r_rr_ptr;
    w_found = 1'b0;
    idx     = r_rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = r_rr_ptr + 2'(k);
      if (Req[idx]) begin
        w_win   = idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_found && !Tx_busy) w_state_next = S_GRANT;
      S_GRANT:     w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (w_timeout) w_state_next = S_RELEASE;
                   else if (Tx_busy) w_state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (w_timeout || !Tx_busy) w_state_next = S_RELEASE;
      S_RELEASE:   w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Baud_Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= 2'd0;
      r_owner   <= 2'd0;
      r_grant   <= 4'd0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start_frame) begin
        r_owner   <= w_win;
        r_grant   <= 4'b0001 << w_win;
        r_tx_data <= Data[w_win*DATA_W +: DATA_W];
      end else if (w_state_next == S_IDLE) begin
        r_grant <= 4'd0;
      end
      if (r_state == S_RELEASE) r_rr_ptr <= r_owner + 2'd1;
    end
  end

  assign Grant    = r_grant;
  assign Tx_data  = r_tx_data;
  assign Tx_start = (r_state == S_GRANT);
  assign Done     = (r_state == S_RELEASE) ? r_grant : 4'd0;

`ifdef TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_enter_wait;
  logic             r_err;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_timeout    = w_in_wait && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  assign w_enter_wait = (w_state_next != r_state) &&
                        ((w_state_next == S_WAIT_BUSY) || (w_state_next == S_WAIT_DONE));

  // Counter holds the number of cycles already spent in the current wait state.
  always_ff @(posedge Baud_Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_enter_wait)   r_cnt <= '0;
      else if (w_in_wait) r_cnt <= w_cnt_inc;
      r_err <= w_timeout;
    end
  end

  assign Err = r_err && (r_state == S_RELEASE);
`else
  assign w_timeout = 1'b0;
  assign Err       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler; expected grants/payloads flow through a scoreboard queue.
// Covers both the default build and builds with TX_TIMEOUT_EN defined (TIMEOUT_CYCLES=20).
module tb_uart_tx_scheduler;

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } sb_t;

`ifdef TX_TIMEOUT_EN
  localparam int BUSY_LONG = 12;
`else
  localparam int BUSY_LONG = 176;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  Req;
  logic [31:0] Data;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic        Tx_start;
  logic [7:0]  Tx_data;
  logic        Tx_busy;
  logic        Err;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  m_rr;
  sb_t         sb[$];

  uart_tx_scheduler #(.DATA_W(8), .TIMEOUT_CYCLES(20)) dut (
    .Baud_Clk (clk),
    .Reset    (rst_n),
    .Req      (Req),
    .Data     (Data),
    .Grant    (Grant),
    .Done     (Done),
    .Tx_start (Tx_start),
    .Tx_data  (Tx_data),
    .Tx_busy  (Tx_busy),
    .Err      (Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    Req     = 4'd0;
    Tx_busy = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    m_rr  = 2'd0;
  endtask

  // Model a full frame: arbitration, transmitter busy window, Done pulse.
  task automatic run_frame(input int busy_len, input logic [3:0] drop,
                           output int lat, output logic [3:0] gnt);
    sb_t        exp_e;
    sb_t        got;
    logic [1:0] idx;
    logic [1:0] w;
    bit         found;
    int         n;
    found = 0;
    w     = m_rr;
    for (int k = 0; k < 4; k++) begin
      idx = m_rr + 2'(k);
      if (!found && Req[idx]) begin
        found = 1;
        w     = idx;
      end
    end
    exp_e.grant = 4'b0001 << w;
    exp_e.data  = Data[w*8 +: 8];
    sb.push_back(exp_e);
    lat = 0;
    while (!Tx_start && lat < 8) begin
      tick();
      lat++;
    end
    gnt = Grant;
    checks++;
    if (Tx_start !== 1'b1) begin
      errors++;
      $display("FAIL tx_start_timeout: Tx_start=%b after %0d cycles, required 1", Tx_start, lat);
      sb.delete();
      return;
    end
    got = sb.pop_front();
    checks++;
    if (Grant !== got.grant) begin
      errors++;
      $display("FAIL grant: got %b required %b", Grant, got.grant);
    end
    checks++;
    if (Tx_data !== got.data) begin
      errors++;
      $display("FAIL tx_data: got %h required %h", Tx_data, got.data);
    end
    Tx_busy = 1'b1;
    n = 0;
    repeat (busy_len) begin
      tick();
      n++;
      if (n == 3 && drop != 4'd0) Req = Req & ~drop;
    end
    checks++;
    if (Grant !== got.grant || Tx_data !== got.data || Done !== 4'd0) begin
      errors++;
      $display("FAIL hold_mid_frame: grant %b data %h done %b, required %b %h 0000",
               Grant, Tx_data, Done, got.grant, got.data);
    end
    Tx_busy = 1'b0;
    n = 0;
    while (Done === 4'd0 && n < 4) begin
      tick();
      n++;
    end
    checks++;
    if (Done !== got.grant) begin
      errors++;
      $display("FAIL done: got %b required %b", Done, got.grant);
    end
    checks++;
    if (Err !== 1'b0 || Grant !== got.grant) begin
      errors++;
      $display("FAIL release: err %b grant %b, required 0 %b", Err, Grant, got.grant);
    end
    m_rr = w + 2'd1;
    tick();
    checks++;
    if (Done !== 4'd0 || Grant !== 4'd0) begin
      errors++;
      $display("FAIL post_release: done %b grant %b, required 0000 0000", Done, Grant);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    Req     = 4'b1111;
    Data    = 32'h44332211;
    Tx_busy = 1'b0;
    tick();
    tick();
    checks++;
    if (Grant !== 4'd0 || Done !== 4'd0 || Tx_start !== 1'b0 || Tx_data !== 8'd0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant %b done %b start %b data %h err %b, required all 0",
               Grant, Done, Tx_start, Tx_data, Err);
    end
    Req = 4'd0;
    rst_n = 1'b1;
    m_rr = 2'd0;
    tick();
  endtask

  task automatic test_single();
    int         lat;
    logic [3:0] gnt;
    do_reset();
    Data = 32'hD4C3B2A5;
    Req  = 4'b0001;
    run_frame(BUSY_LONG, 4'd0, lat, gnt);
    Req = 4'd0;
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL req_to_start_latency: got %0d required 1", lat);
    end
  endtask

  task automatic test_contention();
    int         lat;
    logic [3:0] gnt;
    do_reset();
    Data = 32'h44332211;
    Req  = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      run_frame(4, 4'd0, lat, gnt);
      checks++;
      if (gnt !== (4'b0001 << (f % 4))) begin
        errors++;
        $display("FAIL rotation frame %0d: got %b required %b", f, gnt, 4'b0001 << (f % 4));
      end
    end
    Req = 4'd0;
  endtask

  task automatic test_busy_in_idle();
    int         lat;
    logic [3:0] gnt;
    do_reset();
    Data    = 32'h44332211;
    Tx_busy = 1'b1;
    Req     = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (Grant !== 4'd0 || Tx_start !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold cycle %0d: grant %b start %b, required 0000 0", i, Grant, Tx_start);
      end
    end
    Tx_busy = 1'b0;
    tick();
    checks++;
    if (Grant !== 4'b0100) begin
      errors++;
      $display("FAIL busy_release_grant: got %b required 0100", Grant);
    end
    run_frame(4, 4'd0, lat, gnt);
    Req = 4'd0;
  endtask

  task automatic test_req_drop();
    int         lat;
    logic [3:0] gnt;
    do_reset();
    Data = 32'h44332211;
    Req  = 4'b0010;
    run_frame(8, 4'b0010, lat, gnt);
    // Pointer must now sit at 2, so requester 2 beats requester 0.
    Req = 4'b0101;
    run_frame(4, 4'd0, lat, gnt);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL rr_ptr_after_drop: got %b required 0100", gnt);
    end
    Req = 4'd0;
  endtask

  task automatic test_reset_mid_frame();
    int         lat;
    logic [3:0] gnt;
    sb_t        exp_e;
    sb_t        got;
    do_reset();
    Data = 32'h44332211;
    Req  = 4'b0001;
    exp_e.grant = 4'b0001;
    exp_e.data  = 8'h11;
    sb.push_back(exp_e);
    tick();
    checks++;
    if (Tx_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_start: got %b required 1", Tx_start);
    end else begin
      got = sb.pop_front();
      checks++;
      if (Grant !== got.grant || Tx_data !== got.data) begin
        errors++;
        $display("FAIL mid_reset_grant: grant %b data %h required %b %h", Grant, Tx_data, got.grant, got.data);
      end
    end
    Tx_busy = 1'b1;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Grant !== 4'd0 || Done !== 4'd0 || Tx_start !== 1'b0 || Tx_data !== 8'd0 || Err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: grant %b done %b start %b data %h err %b, required all 0",
               Grant, Done, Tx_start, Tx_data, Err);
    end
    sb.delete();
    tick();
    Tx_busy = 1'b0;
    Req     = 4'b1010;
    tick();
    rst_n = 1'b1;
    m_rr  = 2'd0;
    run_frame(4, 4'd0, lat, gnt);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL first_grant_after_reset: got %b required 0010", gnt);
    end
    Req = 4'd0;
  endtask

  task automatic test_timeout();
    int  n;
    sb_t exp_e;
    sb_t got;
    do_reset();
    Data = 32'h44332211;
    Req  = 4'b1000;
    exp_e.grant = 4'b1000;
    exp_e.data  = 8'h44;
    sb.push_back(exp_e);
    tick();
    checks++;
    if (Tx_start !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start: got %b required 1", Tx_start);
      sb.delete();
      return;
    end
    got = sb.pop_front();
    checks++;
    if (Grant !== got.grant || Tx_data !== got.data) begin
      errors++;
      $display("FAIL timeout_grant: grant %b data %h required %b %h", Grant, Tx_data, got.grant, got.data);
    end
`ifdef TX_TIMEOUT_EN
    n = 0;
    while (Done === 4'd0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL timeout_cycles: release %0d cycles after start, required 21", n);
    end
    checks++;
    if (Done !== 4'b1000 || Err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: done %b err %b, required 1000 1", Done, Err);
    end
    Req = 4'd0;
    tick();
    checks++;
    if (Err !== 1'b0 || Grant !== 4'd0) begin
      errors++;
      $display("FAIL timeout_after: err %b grant %b, required 0 0000", Err, Grant);
    end
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (Done !== 4'd0 || Err !== 1'b0 || Grant !== 4'b1000) begin
        errors++;
        $display("FAIL no_timeout cycle %0d: done %b err %b grant %b, required 0000 0 1000", i, Done, Err, Grant);
      end
    end
    Tx_busy = 1'b1;
    tick();
    tick();
    Tx_busy = 1'b0;
    n = 0;
    while (Done === 4'd0 && n < 4) begin
      tick();
      n++;
    end
    checks++;
    if (Done !== 4'b1000 || Err !== 1'b0) begin
      errors++;
      $display("FAIL late_done: done %b err %b, required 1000 0", Done, Err);
    end
    Req = 4'd0;
    tick();
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    Req     = 4'd0;
    Data    = 32'd0;
    Tx_busy = 1'b0;
    m_rr    = 2'd0;
    test_reset();
    test_single();
    test_contention();
    test_busy_in_idle();
    test_req_drop();
    test_reset_mid_frame();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
